// File: rtl/weight_stream_ram.sv
// rtl/weight_stream_ram.sv - column-organised weight memory with burst load and windowed, wrapping stream-out
// Optional out_last flag on the final streamed column is enabled by defining WSRAM_LAST_EN.
module weight_stream_ram #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int BITWIDTH      = 18,
  parameter int ADDR_BITWIDTH = $clog2(NCOL)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NROW*BITWIDTH-1:0]   rowIn,
  output logic                       load_done,
  input  logic                       stream_start,
  input  logic [ADDR_BITWIDTH-1:0]   stream_base,
  input  logic [ADDR_BITWIDTH:0]     stream_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NROW*BITWIDTH-1:0]   rowOut,
`ifdef WSRAM_LAST_EN
  output logic                       out_last,
`endif
  output logic                       busy
);

  localparam int                     W        = NROW * BITWIDTH;
  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic [ADDR_BITWIDTH:0]   MAX_LEN  = (ADDR_BITWIDTH + 1)'(NCOL);
  localparam logic [ADDR_BITWIDTH:0]   ONE_LEN  = (ADDR_BITWIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                   state, state_next;
  logic [W-1:0]             mem [NCOL];
  logic [ADDR_BITWIDTH-1:0] wr_col, rd_col;
  logic [ADDR_BITWIDTH:0]   remaining;
  logic                     start_load, start_stream, do_write, do_read, do_finish;
  logic                     last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Load and stream are mutually exclusive states, so the array never sees a read and write together.
  always_comb begin
    state_next   = state;
    start_load   = 1'b0;
    start_stream = 1'b0;
    do_write     = 1'b0;
    do_read      = 1'b0;
    do_finish    = 1'b0;
    in_ready     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (load_start) begin
          start_load = 1'b1;
          state_next = LOAD;
        end else if (stream_start && stream_len != '0 && stream_len <= MAX_LEN) begin
          start_stream = 1'b1;
          state_next   = STREAM;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          do_write = 1'b1;
          if (wr_col == LAST_COL) state_next = IDLE;
        end
      end
      STREAM: begin
        if (remaining != '0 && (!out_valid || out_ready)) begin
          do_read = 1'b1;
        end else if (remaining == '0 && out_valid && out_ready) begin
          do_finish  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage is deliberately outside the reset domain so weights survive a reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_col] <= rowIn;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_col    <= '0;
      rd_col    <= '0;
      remaining <= '0;
      load_done <= 1'b0;
      out_valid <= 1'b0;
      rowOut    <= '0;
      last_q    <= 1'b0;
    end else begin
      load_done <= do_write && (wr_col == LAST_COL);
      if (start_load)    wr_col <= '0;
      else if (do_write) wr_col <= wr_col + ADDR_BITWIDTH'(1);
      if (start_stream) begin
        rd_col    <= stream_base;
        remaining <= stream_len;
      end else if (do_read) begin
        rowOut    <= mem[rd_col];
        out_valid <= 1'b1;
        rd_col    <= rd_col + ADDR_BITWIDTH'(1);
        remaining <= remaining - ONE_LEN;
        last_q    <= (remaining == ONE_LEN);
      end else if (do_finish) begin
        out_valid <= 1'b0;
        last_q    <= 1'b0;
      end
    end
  end

`ifdef WSRAM_LAST_EN
  assign out_last = last_q;
`else
  logic unused_last;
  assign unused_last = last_q;
`endif

endmodule
